// File: rtl/aes_pkg.sv
// Shared constants for the reduced-width AES core: key lengths, round counts,
// FSM and update encodings, GF(2^4) reduction term and the inverse S-box.
package aes_pkg;

   localparam logic       KEYLEN_128 = 1'b0;
   localparam logic       KEYLEN_256 = 1'b1;
   localparam logic [3:0] NR_128     = 4'ha;
   localparam logic [3:0] NR_256     = 4'he;

   // x^4 + x + 1: an x^4 overflow folds back into the low bits as 4'h3
   localparam logic [3:0] GF_POLY = 4'h3;

   typedef enum logic [2:0] {
      CTRL_IDLE = 3'd0,
      CTRL_INIT = 3'd1,
      CTRL_SBOX = 3'd2,
      CTRL_MAIN = 3'd3
   } ctrl_state_e;

   localparam logic [2:0] UPD_NONE  = 3'd0;
   localparam logic [2:0] UPD_INIT  = 3'd1;
   localparam logic [2:0] UPD_SBOX  = 3'd2;
   localparam logic [2:0] UPD_MAIN  = 3'd3;
   localparam logic [2:0] UPD_FINAL = 3'd4;

   localparam logic [3:0] INV_SBOX [16] = '{
      4'h5, 4'he, 4'hf, 4'h8, 4'hc, 4'h1, 4'h2, 4'hd,
      4'hb, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'ha
   };

   function automatic logic [3:0] num_rounds(input logic keylen);
      return (keylen == KEYLEN_128) ? NR_128 : NR_256;
   endfunction

endpackage

// File: rtl/aes_inv_sbox16.sv
// Combinational inverse S-box over one 16-bit column word (four cell lookups).
module aes_inv_sbox16
   import aes_pkg::*;
(
   input  logic [15:0] word_i,
   output logic [15:0] word_o
);

   for (genvar i = 0; i < 4; i++) begin : g_cell
      assign word_o[4*i +: 4] = INV_SBOX[word_i[4*i +: 4]];
   end

endmodule

// File: rtl/aes_decipher_block.sv
// Iterative decipher datapath: 64-bit block of 4-bit cells, round keys consumed nr..0.
// Define AES_DEC_PARALLEL_SBOX_EN to substitute all four words in a single cycle.
module aes_decipher_block
   import aes_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        next,
   input  logic        keylen,
   output logic [3:0]  round,
   input  logic [63:0] round_key,
   input  logic [63:0] block,
   output logic [63:0] new_block,
   output logic        ready
);

   ctrl_state_e fsm_q, fsm_d;
   logic [63:0] block_q, block_d;
   logic        ready_q, ready_d;
   logic [3:0]  round_ctr_q, round_ctr_d, round_dec;
   logic [1:0]  sword_ctr_q, sword_ctr_d;
   logic [2:0]  upd;

   function automatic logic [3:0] gm2(input logic [3:0] a);
      return {a[2:0], 1'b0} ^ (GF_POLY & {4{a[3]}});
   endfunction

   // Row k uses the coefficients (E,B,D,9) rotated right by k.
   function automatic logic [15:0] inv_mix_col(input logic [15:0] w);
      logic [3:0] b [4];
      logic [3:0] m9 [4];
      logic [3:0] mb [4];
      logic [3:0] md [4];
      logic [3:0] me [4];
      logic [3:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         b[i]  = w[15 - 4*i -: 4];
         x2    = gm2(b[i]);
         x4    = gm2(x2);
         x8    = gm2(x4);
         m9[i] = x8 ^ b[i];
         mb[i] = x8 ^ x2 ^ b[i];
         md[i] = x8 ^ x4 ^ b[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   function automatic logic [63:0] inv_mix(input logic [63:0] s);
      return {inv_mix_col(s[63:48]), inv_mix_col(s[47:32]),
              inv_mix_col(s[31:16]), inv_mix_col(s[15:0])};
   endfunction

   function automatic logic [63:0] inv_shift(input logic [63:0] s);
      logic [63:0] o;
      o = '0;
      for (int j = 0; j < 4; j++) begin
         for (int r = 0; r < 4; r++) begin
            o[63 - 16*j - 4*r -: 4] = s[63 - 16*((j + r) % 4) - 4*r -: 4];
         end
      end
      return o;
   endfunction

`ifdef AES_DEC_PARALLEL_SBOX_EN
   logic [63:0] sbox_all;

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_inv_sbox16 u_sbox (
         .word_i (block_q[16*g +: 16]),
         .word_o (sbox_all[16*g +: 16])
      );
   end
`else
   logic [15:0] sbox_in, sbox_out;

   always_comb begin
      case (sword_ctr_q)
         2'd0: sbox_in = block_q[63:48];
         2'd1: sbox_in = block_q[47:32];
         2'd2: sbox_in = block_q[31:16];
         2'd3: sbox_in = block_q[15:0];
      endcase
   end

   aes_inv_sbox16 u_sbox (
      .word_i (sbox_in),
      .word_o (sbox_out)
   );
`endif

   assign round_dec = (round_ctr_q == 4'd0) ? 4'd0 : round_ctr_q - 4'd1;

   always_comb begin
      fsm_d       = fsm_q;
      upd         = UPD_NONE;
      ready_d     = ready_q;
      round_ctr_d = round_ctr_q;
      sword_ctr_d = sword_ctr_q;
      case (fsm_q)
         CTRL_IDLE: begin
            if (next) begin
               ready_d     = 1'b0;
               round_ctr_d = num_rounds(keylen);
               fsm_d       = CTRL_INIT;
            end
         end
         CTRL_INIT: begin
            upd         = UPD_INIT;
            round_ctr_d = round_dec;
            sword_ctr_d = 2'd0;
            fsm_d       = CTRL_SBOX;
         end
         CTRL_SBOX: begin
            upd = UPD_SBOX;
`ifdef AES_DEC_PARALLEL_SBOX_EN
            fsm_d = CTRL_MAIN;
`else
            sword_ctr_d = sword_ctr_q + 2'd1;
            if (sword_ctr_q == 2'd3) fsm_d = CTRL_MAIN;
`endif
         end
         CTRL_MAIN: begin
            if (round_ctr_q != 4'd0) begin
               upd         = UPD_MAIN;
               round_ctr_d = round_dec;
               sword_ctr_d = 2'd0;
               fsm_d       = CTRL_SBOX;
            end else begin
               upd     = UPD_FINAL;
               ready_d = 1'b1;
               fsm_d   = CTRL_IDLE;
            end
         end
         default: fsm_d = CTRL_IDLE;
      endcase
   end

   always_comb begin
      block_d = block_q;
      case (upd)
         UPD_INIT: block_d = inv_shift(block ^ round_key);
         UPD_SBOX: begin
`ifdef AES_DEC_PARALLEL_SBOX_EN
            block_d = sbox_all;
`else
            case (sword_ctr_q)
               2'd0: block_d[63:48] = sbox_out;
               2'd1: block_d[47:32] = sbox_out;
               2'd2: block_d[31:16] = sbox_out;
               2'd3: block_d[15:0]  = sbox_out;
            endcase
`endif
         end
         UPD_MAIN:  block_d = inv_shift(inv_mix(block_q ^ round_key));
         UPD_FINAL: block_d = block_q ^ round_key;
         default:   block_d = block_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q       <= CTRL_IDLE;
         block_q     <= '0;
         ready_q     <= 1'b1;
         round_ctr_q <= 4'd0;
         sword_ctr_q <= 2'd0;
      end else begin
         fsm_q       <= fsm_d;
         block_q     <= block_d;
         ready_q     <= ready_d;
         round_ctr_q <= round_ctr_d;
         sword_ctr_q <= sword_ctr_d;
      end
   end

   assign new_block = block_q;
   assign ready     = ready_q;
   assign round     = round_ctr_q;

endmodule

// File: tb/tb_aes_decipher_block.sv
// Randomized self-checking bench for aes_decipher_block against a cell-level
// reference model (generic GF(2^4) multiply, matrix rows, table lookups).
module tb_aes_decipher_block;

`ifdef AES_DEC_PARALLEL_SBOX_EN
   localparam int PERIOD_EDGES = 2;
   localparam int LAT_128      = 21;
   localparam int LAT_256      = 29;
`else
   localparam int PERIOD_EDGES = 5;
   localparam int LAT_128      = 51;
   localparam int LAT_256      = 71;
`endif

   typedef logic [0:3][0:3][3:0] cells_t;

   localparam logic [3:0] COEF [4] = '{4'he, 4'hb, 4'hd, 4'h9};
   localparam logic [3:0] SBOX_TBL [16] = '{
      4'h5, 4'he, 4'hf, 4'h8, 4'hc, 4'h1, 4'h2, 4'hd,
      4'hb, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'ha
   };

   logic        clk = 1'b0;
   logic        reset_n;
   logic        next;
   logic        keylen;
   logic [3:0]  round;
   logic [63:0] round_key;
   logic [63:0] block;
   logic [63:0] new_block;
   logic        ready;
   logic [63:0] keyTbl [16];

   int vectors    = 0;
   int miscompares = 0;

   bit          mBusy    = 1'b0;
   int          mCnt     = 0;
   int          mNr      = 0;
   int          mLat     = 0;
   logic [63:0] mResult  = '0;
   logic [63:0] mPending = '0;

   aes_decipher_block dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .next      (next),
      .keylen    (keylen),
      .round     (round),
      .round_key (round_key),
      .block     (block),
      .new_block (new_block),
      .ready     (ready)
   );

   always #5 clk = ~clk;

   assign round_key = keyTbl[round];

   function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] p;
      p = '0;
      for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (8'(a) << i);
      for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
      return p[3:0];
   endfunction

   function automatic cells_t shiftRows(input cells_t a);
      cells_t o;
      for (int j = 0; j < 4; j++)
         for (int r = 0; r < 4; r++) o[j][r] = a[(j + r) % 4][r];
      return o;
   endfunction

   function automatic cells_t mixCols(input cells_t a);
      cells_t o;
      logic [3:0] acc;
      for (int j = 0; j < 4; j++) begin
         for (int k = 0; k < 4; k++) begin
            acc = '0;
            for (int i = 0; i < 4; i++) acc = acc ^ gmul(COEF[(i - k + 4) % 4], a[j][i]);
            o[j][k] = acc;
         end
      end
      return o;
   endfunction

   function automatic cells_t subCells(input cells_t a);
      cells_t o;
      for (int j = 0; j < 4; j++)
         for (int r = 0; r < 4; r++) o[j][r] = SBOX_TBL[a[j][r]];
      return o;
   endfunction

   function automatic logic [63:0] refDecipher(input logic [63:0] blk, input logic kl);
      int nr;
      cells_t s;
      nr = kl ? 14 : 10;
      s = shiftRows(blk ^ keyTbl[nr]);
      for (int r = nr - 1; r >= 1; r--) s = shiftRows(mixCols(subCells(s) ^ keyTbl[r]));
      return subCells(s) ^ keyTbl[0];
   endfunction

   function automatic logic [3:0] expRound();
      int v;
      if (!mBusy) return 4'd0;
      if (mCnt == 0) return 4'(mNr);
      v = mNr - 1 - (mCnt - 1) / PERIOD_EDGES;
      return (v < 0) ? 4'd0 : 4'(v);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference timeline: one accepted start, then a fixed number of edges to the result
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mBusy   = 1'b0;
         mCnt    = 0;
         mResult = '0;
      end else if (mBusy) begin
         mCnt++;
         if (mCnt == mLat) begin
            mBusy   = 1'b0;
            mResult = mPending;
         end
      end else if (next) begin
         mBusy    = 1'b1;
         mCnt     = 0;
         mNr      = keylen ? 14 : 10;
         mLat     = 1 + PERIOD_EDGES * mNr;
         mPending = refDecipher(block, keylen);
      end
   end

   always @(negedge clk) begin
      checkOutput("ready", 64'(ready), 64'(!mBusy));
      checkOutput("round", 64'(round), 64'(expRound()));
      if (!mBusy) checkOutput("new_block", new_block, mResult);
   end

   task automatic randomKeys();
      for (int i = 0; i < 16; i++) keyTbl[i] = {$urandom, $urandom};
   endtask

   task automatic applyStimulus(input logic kl, input logic [63:0] blk, input int pokeAt,
                                input bit noisy, input int expLat);
      int edges;
      keylen = kl;
      block  = blk;
      @(negedge clk);
      next = 1'b1;
      @(negedge clk);
      next  = 1'b0;
      edges = 0;
      while (!ready && edges < 200) begin
         if (edges == pokeAt) next = 1'b1;
         else if (noisy)      next = 1'($urandom_range(0, 1));
         else                 next = 1'b0;
         @(negedge clk);
         edges++;
      end
      next = 1'b0;
      checkOutput("latency", 64'(edges), 64'(expLat));
   endtask

   task automatic applyResetMidRun();
      keylen = 1'b0;
      block  = {$urandom, $urandom};
      @(negedge clk);
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
      repeat (20) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("midrun_reset_ready", 64'(ready), 64'd1);
      checkOutput("midrun_reset_block", new_block, 64'd0);
      checkOutput("midrun_reset_round", 64'(round), 64'd0);
      @(negedge clk);
      #2 reset_n = 1'b1;
   endtask

   initial begin
      logic [63:0] blk;
      logic        kl;
      reset_n = 1'b1;
      next    = 1'b0;
      keylen  = 1'b0;
      block   = '0;
      for (int i = 0; i < 16; i++) keyTbl[i] = '0;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_ready", 64'(ready), 64'd1);
      checkOutput("reset_block", new_block, 64'd0);
      checkOutput("reset_round", 64'(round), 64'd0);

      checkOutput("model_gmul_2_8", 64'(gmul(4'h2, 4'h8)), 64'h3);
      checkOutput("model_gmul_e_9", 64'(gmul(4'he, 4'h9)), 64'h7);
      checkOutput("model_zero_128", refDecipher(64'd0, 1'b0), 64'hEEEE_EEEE_EEEE_EEEE);
      checkOutput("model_zero_256", refDecipher(64'd0, 1'b1), 64'h0);
      checkOutput("model_5555_128", refDecipher(64'h5555_5555_5555_5555, 1'b0), 64'h9999_9999_9999_9999);

      #2 reset_n = 1'b1;
      applyStimulus(1'b0, 64'd0, -1, 1'b0, LAT_128);
      checkOutput("zero_128", new_block, 64'hEEEE_EEEE_EEEE_EEEE);
      applyStimulus(1'b1, 64'd0, -1, 1'b0, LAT_256);
      checkOutput("zero_256", new_block, 64'h0);
      applyStimulus(1'b0, 64'h5555_5555_5555_5555, -1, 1'b0, LAT_128);
      checkOutput("five_128", new_block, 64'h9999_9999_9999_9999);
      applyStimulus(1'b0, 64'd0, 9, 1'b0, LAT_128);
      checkOutput("next_while_busy", new_block, 64'hEEEE_EEEE_EEEE_EEEE);

      randomKeys();
      applyResetMidRun();
      blk = {$urandom, $urandom};
      applyStimulus(1'b1, blk, -1, 1'b0, LAT_256);
      checkOutput("after_reset", new_block, refDecipher(blk, 1'b1));

      for (int n = 0; n < 8; n++) begin
         randomKeys();
         kl  = 1'($urandom_range(0, 1));
         blk = {$urandom, $urandom};
         applyStimulus(kl, blk, -1, 1'b1, kl ? LAT_256 : LAT_128);
         checkOutput("random_run", new_block, refDecipher(blk, kl));
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
